long_fifo_4bit_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that lets NUM independent 4-bit nibble streams share one long 4-bit FIFO write port. Grants one requester at a time for a burst, which ends on `last` or after MAX_BURST beats. It sits in the write clock domain, directly in front of the long FIFO's din/wr_en/full.

---
 rtl/long_fifo_4bit_pkg.sv | 31 +++
 rtl/rr_arbiter_pick.sv | 18 +
 rtl/long_fifo_4bit_wr_arbiter.sv | 125 ++++++++++++
 tb/tb_long_fifo_4bit_wr_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/long_fifo_4bit_pkg.sv
// Shared types and helpers for the long 4-bit FIFO write-side arbiter.
// The round-robin pick function serves arbiters of up to RR_MAX requesters.
package long_fifo_4bit_pkg;

    localparam int NIBBLE_W = 4;
    localparam int RR_MAX   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HEAD  = 2'd1,
        BURST = 2'd2
    } arb_state_e;

    // First set bit of valid at or above ptr, wrapping mod num. The descending
    // scan lets the smallest offset from ptr win. Returns ptr when none is set.
    function automatic int rr_pick(input logic [RR_MAX-1:0] valid,
                                   input int ptr,
                                   input int num);
        int idx;
        int j;
        idx = ptr;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            if (k < num) begin
                j = (ptr + k) % num;
                if (valid[j]) idx = j;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin priority encoder: the first valid index at or
// after ptr, wrapping. Shared by the schedulers in this codebase.
module rr_arbiter_pick
    import long_fifo_4bit_pkg::*;
#(
    parameter int NUM   = 4,
    parameter int IDX_W = $clog2(NUM)
) (
    input  logic [NUM-1:0]   valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    assign idx = IDX_W'(rr_pick(RR_MAX'(valid), int'(ptr), NUM));
    assign any = |valid;

endmodule

// File: rtl/long_fifo_4bit_wr_arbiter.sv
// Round-robin arbiter that multiplexes NUM nibble streams onto one long FIFO
// write port. Define LONG_FIFO_WR_ARB_HEADER_EN to prefix each burst with its channel id.
module long_fifo_4bit_wr_arbiter
    import long_fifo_4bit_pkg::*;
#(
    parameter int NUM       = 4,
    parameter int MAX_BURST = 256,
    parameter int BCNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM-1:0]          s_valid,
    input  logic [NUM*NIBBLE_W-1:0] s_data,
    input  logic [NUM-1:0]          s_last,
    output logic [NUM-1:0]          s_ready,
    output logic [NIBBLE_W-1:0]     fifo_din,
    output logic                    fifo_wr_en,
    input  logic                    fifo_full,
    output logic [NUM-1:0]          grant,
    output logic                    busy
);

    localparam int IDX_W = $clog2(NUM);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM-1:0]    grant_d;
    logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              beat_acc;
    logic              burst_end;

    rr_arbiter_pick #(
        .NUM   (NUM),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (s_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gidx_q     <= '0;
            grant      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gidx_q     <= gidx_d;
            grant      <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gidx_d     = gidx_q;
        grant_d    = grant;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        s_ready    = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        beat_acc   = 1'b0;
        burst_end  = 1'b0;

        case (state_q)
            IDLE: begin
                // Arbitration cycle: nothing is accepted here, even if valid.
                if (pick_any) begin
                    gidx_d     = pick_idx;
                    grant_d    = NUM'(1) << pick_idx;
                    beat_cnt_d = '0;
`ifdef LONG_FIFO_WR_ARB_HEADER_EN
                    state_d    = HEAD;
`else
                    state_d    = BURST;
`endif
                end
            end

`ifdef LONG_FIFO_WR_ARB_HEADER_EN
            HEAD: begin
                fifo_din   = NIBBLE_W'(gidx_q);
                fifo_wr_en = !fifo_full;
                if (!fifo_full) state_d = BURST;
            end
`endif

            BURST: begin
                s_ready[gidx_q] = !fifo_full;
                beat_acc        = s_valid[gidx_q] && !fifo_full;
                fifo_wr_en      = beat_acc;
                fifo_din        = s_data[int'(gidx_q)*NIBBLE_W +: NIBBLE_W];
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                    burst_end  = s_last[gidx_q] ||
                                 (beat_cnt_q == BCNT_W'(MAX_BURST - 1));
                end
                // A forced release may split a packet; the tail waits its turn.
                if (burst_end) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (gidx_q == IDX_W'(NUM - 1)) ? '0
                                                             : gidx_q + IDX_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_long_fifo_4bit_wr_arbiter.sv
// Directed bench for long_fifo_4bit_wr_arbiter (NUM=4, MAX_BURST=4).
// Build with LONG_FIFO_WR_ARB_HEADER_EN to exercise the channel-id header path.
module tb_long_fifo_4bit_wr_arbiter;

    localparam int NUM       = 4;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM-1:0]    s_valid;
    logic [NUM*4-1:0]  s_data;
    logic [NUM-1:0]    s_last;
    logic [NUM-1:0]    s_ready;
    logic [3:0]        fifo_din;
    logic              fifo_wr_en;
    logic              fifo_full;
    logic [NUM-1:0]    grant;
    logic              busy;

    long_fifo_4bit_wr_arbiter #(
        .NUM       (NUM),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [4:0] mem [NUM][32];
    int         hd [NUM];
    int         tl [NUM];
    logic [3:0] wlog [$];
    logic [3:0] glog [$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         viol;
    logic       full_tgl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input logic [3:0] got[$],
                           input logic [63:0] exp, input int n);
        chk({tag, "_len"}, got.size(), n);
        for (int k = 0; k < n; k++)
            chk($sformatf("%s[%0d]", tag, k), 32'(got[k]), 32'(exp[4*(n-1-k) +: 4]));
    endtask

    task automatic push(input int ch, input logic [3:0] d, input logic l);
        mem[ch][tl[ch]] = {l, d};
        tl[ch]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NUM; i++) begin
            if (hd[i] < tl[i]) begin
                s_valid[i]       = 1'b1;
                s_data[i*4 +: 4] = mem[i][hd[i]][3:0];
                s_last[i]        = mem[i][hd[i]][4];
            end else begin
                s_valid[i]       = 1'b0;
                s_data[i*4 +: 4] = 4'h0;
                s_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        wlog.delete();
        glog.delete();
        viol = 0;
    endtask

    // Called at a negedge: sample just before the next posedge, then pop
    // accepted beats and update inputs at the following negedge.
    task automatic tick();
        logic [NUM-1:0] acc;
        #4;
        acc = s_valid & s_ready;
        if (fifo_wr_en) wlog.push_back(fifo_din);
        glog.push_back(grant);
        if (fifo_full && (fifo_wr_en || (|s_ready))) viol++;
        @(negedge clk);
        for (int i = 0; i < NUM; i++)
            if (acc[i]) hd[i]++;
        if (full_tgl) fifo_full = ~fifo_full;
        drive();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        fifo_full = 1'b0;
        full_tgl  = 1'b0;
        clear_all();
        drive();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        fifo_full = 1'b0;
        full_tgl  = 1'b0;
        clear_all();
        push(0, 4'h5, 1'b1);
        push(1, 4'h6, 1'b1);
        drive();
        repeat (2) @(negedge clk);
        #2;
        chk("rst_grant",   32'(grant),      0);
        chk("rst_ready",   32'(s_ready),    0);
        chk("rst_wr_en",   32'(fifo_wr_en), 0);
        chk("rst_din",     32'(fifo_din),   0);
        chk("rst_busy",    32'(busy),       0);
        @(negedge clk);

`ifdef LONG_FIFO_WR_ARB_HEADER_EN
        do_reset();
        push(1, 4'h5, 1'b0); push(1, 4'h6, 1'b0); push(1, 4'h7, 1'b1);
        push(3, 4'h8, 1'b0); push(3, 4'h9, 1'b0); push(3, 4'hA, 1'b1);
        drive();
        repeat (12) tick();
        chk_seq("hdr_din",   wlog, 64'h1567389A, 8);
        chk_seq("hdr_grant", glog, 64'h022220888800, 12);
`else
        // Single requester, 5-beat packet: forced split after MAX_BURST beats.
        do_reset();
        for (int k = 1; k <= 5; k++) push(0, 4'(k), k == 5);
        drive();
        repeat (8) tick();
        chk_seq("t1_din",   wlog, 64'h12345, 5);
        chk_seq("t1_grant", glog, 64'h01111010, 8);
        chk("t1_busy_idle", 32'(busy), 0);

        // All four requesters: rotation 0,1,2,3,0 with an idle cycle between.
        do_reset();
        push(0, 4'h1, 1'b0); push(0, 4'h2, 1'b1);
        push(1, 4'h3, 1'b0); push(1, 4'h4, 1'b1);
        push(2, 4'h5, 1'b0); push(2, 4'h6, 1'b1);
        push(3, 4'h7, 1'b0); push(3, 4'h8, 1'b1);
        push(0, 4'h9, 1'b0); push(0, 4'hA, 1'b1);
        drive();
        repeat (16) tick();
        chk_seq("t2_din",   wlog, 64'h123456789A, 10);
        chk_seq("t2_grant", glog, 64'h0110220440880110, 16);

        // 10-beat ch2 packet with ch3 waiting: split, ch3 interleaves.
        do_reset();
        for (int k = 0; k < 10; k++) push(2, 4'(k), k == 9);
        push(3, 4'hD, 1'b0); push(3, 4'hE, 1'b0); push(3, 4'hF, 1'b1);
        drive();
        repeat (18) tick();
        chk_seq("t3_din", wlog, 64'h0123DEF456789, 13);

        // fifo_full toggling every cycle during a burst.
        do_reset();
        push(1, 4'hA, 1'b0); push(1, 4'hB, 1'b0); push(1, 4'hC, 1'b1);
        fifo_full = 1'b1;
        full_tgl  = 1'b1;
        drive();
        repeat (12) tick();
        full_tgl  = 1'b0;
        fifo_full = 1'b0;
        chk("t4_full_viol", viol, 0);
        chk_seq("t4_din", wlog, 64'hABC, 3);
        chk("t4_sent_eq_written", wlog.size(), hd[1]);

        // Async reset mid-burst: immediate release, pointer back to 0.
        do_reset();
        push(1, 4'hB, 1'b1);
        push(2, 4'h1, 1'b0); push(2, 4'h2, 1'b0); push(2, 4'h3, 1'b1);
        drive();
        repeat (4) tick();
        chk_seq("t5_pre_grant", glog, 64'h0204, 4);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_grant", 32'(grant),      0);
        chk("t5_async_wr_en", 32'(fifo_wr_en), 0);
        chk("t5_async_ready", 32'(s_ready),    0);
        chk("t5_async_busy",  32'(busy),       0);
        @(negedge clk);
        rst = 1'b0;
        wlog.delete();
        glog.delete();
        push(0, 4'h7, 1'b1);
        drive();
        repeat (4) tick();
        chk_seq("t5_post_grant", glog, 64'h0104, 4);
        chk_seq("t5_post_din",   wlog, 64'h72, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
